// File: rtl/uproc_pkg.sv
// rtl/uproc_pkg.sv - shared types and constants for the uProcessor control path
package uproc_pkg;

  localparam int NUM_REGS = 4;
  localparam logic [NUM_REGS-1:0] RO_MASK_DEFAULT = 4'b1000;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LD   = 4'h1,
    OP_ST   = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_READ,
    S_WRITE,
    S_HALT
  } id_state_e;

  // LD moves the register straight into the accumulator, so it rides the ALU as PASS.
  function automatic alu_op_e alu_of(input opcode_e op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// rtl/reg_sel_dec.sv - register index to one-hot select, all-zero when disabled
module reg_sel_dec #(
  parameter int NUM_REGS = 4
) (
  input  logic [1:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - instruction decode sequencer driving register file and accumulator enables
module instr_decode
  import uproc_pkg::*;
#(
  parameter int NUM_REGS = uproc_pkg::NUM_REGS,
  parameter logic [NUM_REGS-1:0] RO_MASK = RO_MASK_DEFAULT
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [7:0]          Instr,
  input  logic                InstrValid,
  output logic                InstrReady,
  output logic [NUM_REGS-1:0] RegNum,
  output logic                RegCE,
  output logic                AccuCE,
  output logic [2:0]          AluOp,
  output logic                IllegalInstr,
  output logic                Halted
);

  id_state_e state, state_nxt;
  logic [7:0] ir;
  opcode_e    op;
  logic [1:0] idx;
  logic       sel_en;
  logic       reg_ce_raw;
  logic       accu_ce_raw;
  logic       illegal_raw;
  alu_op_e    alu_raw;
  logic       unused_rsvd;

  assign op          = opcode_e'(ir[7:4]);
  assign idx         = ir[1:0];
  assign unused_rsvd = ^ir[3:2];

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && InstrValid) begin
        ir <= Instr;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    InstrReady  = 1'b0;
    Halted      = 1'b0;
    sel_en      = 1'b0;
    reg_ce_raw  = 1'b0;
    accu_ce_raw = 1'b0;
    illegal_raw = 1'b0;
    alu_raw     = ALU_PASS;
    case (state)
      S_FETCH: begin
        InstrReady = 1'b1;
        if (InstrValid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_NOP:  state_nxt = S_FETCH;
          OP_HALT: state_nxt = S_HALT;
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_nxt = S_READ;
          OP_ST: begin
            // Read-only registers (e.g. the external input port) reject stores.
            if (RO_MASK[idx]) begin
              illegal_raw = 1'b1;
              state_nxt   = S_FETCH;
            end else begin
              state_nxt = S_WRITE;
            end
          end
          default: begin
            illegal_raw = 1'b1;
            state_nxt   = S_FETCH;
          end
        endcase
      end
      S_READ: begin
        sel_en      = 1'b1;
        accu_ce_raw = 1'b1;
        alu_raw     = alu_of(op);
        state_nxt   = S_FETCH;
      end
      S_WRITE: begin
        sel_en     = 1'b1;
        reg_ce_raw = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset masks the enables combinationally so an in-flight READ/WRITE has no effect.
  assign RegCE        = reg_ce_raw  & ~Reset;
  assign AccuCE       = accu_ce_raw & ~Reset;
  assign IllegalInstr = illegal_raw & ~Reset;
  assign AluOp        = AccuCE ? alu_raw : ALU_PASS;

  reg_sel_dec #(.NUM_REGS(NUM_REGS)) u_sel (
    .idx (idx),
    .en  (sel_en),
    .sel (RegNum)
  );

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - self-checking bench for instr_decode
module tb_instr_decode;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] Instr;
  logic       InstrValid;
  logic       InstrReady;
  logic [3:0] RegNum;
  logic       RegCE;
  logic       AccuCE;
  logic [2:0] AluOp;
  logic       IllegalInstr;
  logic       Halted;

  always #5 clk = ~clk;

  instr_decode #(.NUM_REGS(4), .RO_MASK(4'b1000)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .RegNum       (RegNum),
    .RegCE        (RegCE),
    .AccuCE       (AccuCE),
    .AluOp        (AluOp),
    .IllegalInstr (IllegalInstr),
    .Halted       (Halted)
  );

  typedef struct {
    logic [7:0] instr;
    logic       ill;
    logic [3:0] rn;
    logic       acc;
    logic       rce;
    logic [2:0] alu;
    int         len;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       armed = 1'b0;
  logic [3:0] ro_mask = 4'b1000;
  logic [2:0] alu_tab [0:7];
  vec_t       tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      n_cmp++;
      if (RegCE && AccuCE) begin
        n_bad++;
        $display("FAIL ce_exclusive: got RegCE=%0b AccuCE=%0b expected not both 1", RegCE, AccuCE);
      end
      n_cmp++;
      if (!AccuCE && AluOp !== 3'd0) begin
        n_bad++;
        $display("FAIL aluop_idle: got %0d expected 0", AluOp);
      end
    end
  end

  // ISA-level expectation for one instruction (HALT handled separately).
  function automatic vec_t model(input logic [7:0] i);
    vec_t       v;
    logic [3:0] op;
    logic [1:0] idx;
    op  = i[7:4];
    idx = i[1:0];
    v   = '{i, 1'b0, 4'b0, 1'b0, 1'b0, 3'd0, 2};
    if (op >= 4'd8) begin
      v.ill = 1'b1;
    end else if (op == 4'd2) begin
      if (ro_mask[idx]) v.ill = 1'b1;
      else begin
        v.rce = 1'b1;
        v.rn  = 4'b0001 << idx;
        v.len = 3;
      end
    end else if (op != 4'd0) begin
      v.acc = 1'b1;
      v.rn  = 4'b0001 << idx;
      v.alu = alu_tab[op[2:0]];
      v.len = 3;
    end
    return v;
  endfunction

  task automatic do_instr(input vec_t v);
    int    w;
    string t;
    w = 0;
    t = $sformatf("%02h", v.instr);
    while (!InstrReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({"ready_wait_", t}, InstrReady, 1);
    Instr      = v.instr;
    InstrValid = 1'b1;
    @(negedge clk);
    InstrValid = 1'b0;
    Instr      = 8'($urandom);
    check({"dec_ready_", t}, InstrReady, 0);
    check({"dec_illegal_", t}, IllegalInstr, v.ill);
    check({"dec_enables_", t}, {RegCE, AccuCE, RegNum}, 0);
    if (v.len == 3) begin
      @(negedge clk);
      check({"exec_regnum_", t}, RegNum, v.rn);
      check({"exec_accuce_", t}, AccuCE, v.acc);
      check({"exec_regce_", t}, RegCE, v.rce);
      check({"exec_aluop_", t}, AluOp, v.alu);
      check({"exec_illegal_", t}, IllegalInstr, 0);
      check({"exec_ready_", t}, InstrReady, 0);
    end
    @(negedge clk);
    check({"next_ready_", t}, InstrReady, 1);
    check({"next_enables_", t}, {IllegalInstr, RegCE, AccuCE, RegNum}, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] r;
    alu_tab    = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    Reset      = 1'b1;
    Instr      = 8'h00;
    InstrValid = 1'b0;

    // Reset: two cycles, outputs quiet during and ready after release.
    @(negedge clk);
    @(negedge clk);
    check("rst_outputs", {RegNum, RegCE, AccuCE, AluOp, IllegalInstr, Halted}, 0);
    Reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    check("rst_ready", InstrReady, 1);
    check("rst_outputs_after", {RegNum, RegCE, AccuCE, AluOp, IllegalInstr, Halted}, 0);

    tbl.push_back('{8'h11, 1'b0, 4'b0010, 1'b1, 1'b0, 3'd0, 3});
    tbl.push_back('{8'h22, 1'b0, 4'b0100, 1'b0, 1'b1, 3'd0, 3});
    tbl.push_back('{8'h32, 1'b0, 4'b0100, 1'b1, 1'b0, 3'd1, 3});
    tbl.push_back('{8'h23, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 2});
    tbl.push_back('{8'h90, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 2});
    tbl.push_back('{8'h00, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 2});
    tbl.push_back('{8'h43, 1'b0, 4'b1000, 1'b1, 1'b0, 3'd2, 3});
    tbl.push_back('{8'h50, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd3, 3});
    tbl.push_back('{8'h61, 1'b0, 4'b0010, 1'b1, 1'b0, 3'd4, 3});
    tbl.push_back('{8'h72, 1'b0, 4'b0100, 1'b1, 1'b0, 3'd5, 3});
    tbl.push_back('{8'h2D, 1'b0, 4'b0010, 1'b0, 1'b1, 3'd0, 3});
    tbl.push_back('{8'hEC, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 2});
    tbl.push_back('{8'h13, 1'b0, 4'b1000, 1'b1, 1'b0, 3'd0, 3});
    foreach (tbl[k]) do_instr(tbl[k]);

    for (int k = 0; k < 60; k++) begin
      r = 8'($urandom);
      if (r[7:4] == 4'hF) r[7:4] = 4'($urandom_range(0, 14));
      do_instr(model(r));
    end

    // Reset landing in the WRITE cycle of ST R0 suppresses the write.
    Instr      = 8'h20;
    InstrValid = 1'b1;
    @(negedge clk);
    InstrValid = 1'b0;
    check("rstw_decode_ready", InstrReady, 0);
    @(posedge clk);
    #1 Reset = 1'b1;
    @(negedge clk);
    check("rstw_regce", RegCE, 0);
    check("rstw_accuce", AccuCE, 0);
    @(negedge clk);
    check("rstw_fetch_ready", InstrReady, 1);
    Reset = 1'b0;
    @(negedge clk);
    do_instr(model(8'h11));

    // HALT: sticky, blocks further instructions until reset.
    Instr      = 8'hF0;
    InstrValid = 1'b1;
    @(negedge clk);
    check("halt_decode_halted", Halted, 0);
    check("halt_decode_illegal", IllegalInstr, 0);
    Instr = 8'h11;
    @(negedge clk);
    check("halt_halted", Halted, 1);
    check("halt_ready", InstrReady, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("halt_hold", {InstrReady, RegCE, AccuCE, RegNum, Halted}, 1);
    end
    InstrValid = 1'b0;
    Reset      = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check("halt_cleared", Halted, 0);
    check("halt_ready_after_reset", InstrReady, 1);
    do_instr(model(8'h32));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction-decode sequencer for the 8-bit uProcessor; it drives the register file's control side. It accepts 8-bit instructions over a valid/ready handshake and decodes the register field to a one-hot `RegNum`. It then runs a fixed multi-cycle sequence that either reads a register into the accumulator path (`AccuCE` + `AluOp`) or writes the accumulator into a register (`RegCE`). It sits between instruction fetch and the register file/ALU/accumulator.

## Interface
- `NUM_REGS`, 4: register count; `RegNum` width.
- `RO_MASK`, 4'b1000: one bit per register; a set bit marks that register read-only (R3 = external input).
- `clk` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `Instr` in 8: instruction; `[7:4]` opcode, `[3:2]` reserved (ignored), `[1:0]` register index.
- `InstrValid` in 1: `Instr` is valid.
- `InstrReady` out 1: decoder accepts an instruction this cycle.
- `RegNum` out NUM_REGS: one-hot register select; all-zero when not in READ/WRITE.
- `RegCE` out 1: register write enable.
- `AccuCE` out 1: accumulator load enable.
- `AluOp` out 3: ALU operation; PASS=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5.
- `IllegalInstr` out 1: one-cycle pulse on an illegal instruction.
- `Halted` out 1: set by HALT; cleared only by `Reset`.

## Operation
- Opcodes: 0 NOP, 1 LD (Accu <= R), 2 ST (R <= Accu), 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR (Accu <= Accu op R), F HALT. Opcodes 8–E are illegal. ST to a register with a set `RO_MASK` bit is illegal.
- The instruction register captures `Instr` on the handshake and holds it until the next handshake.
- States (package enum):
  - FETCH: `InstrReady`=1. On `InstrValid` → DECODE, capturing `Instr`; otherwise stay.
  - DECODE: all enables 0.
    - NOP → FETCH.
    - Illegal → pulse `IllegalInstr`, → FETCH.
    - HALT → HALT.
    - ST → WRITE.
    - LD/ALU → READ.
  - READ: `RegNum`=onehot(idx), `AccuCE`=1. `AluOp` = PASS for LD, else the matching op. → FETCH.
  - WRITE: `RegNum`=onehot(idx), `RegCE`=1 for exactly this cycle. → FETCH.
  - HALT: `Halted`=1, `InstrReady`=0, all enables 0. Stays until `Reset`.
- `AluOp`=PASS whenever `AccuCE`=0.
- `RegCE` and `AccuCE` are never both 1.
- Reset values: state FETCH, instruction register 0, `RegNum`=0, `RegCE`=0, `AccuCE`=0, `AluOp`=0, `IllegalInstr`=0, `Halted`=0.
- While `Reset`=1, `RegCE`, `AccuCE` and `IllegalInstr` are combinationally forced to 0. A reset in READ/WRITE therefore causes no register or accumulator update.
- `InstrValid` outside FETCH is ignored; the source holds `Instr` until ready.

## Timing
- Handshake edge N (FETCH). DECODE occupies N+1. READ/WRITE occupies N+2. The next FETCH is N+3, giving 3 cycles per LD/ST/ALU instruction.
- NOP/illegal: DECODE at N+1, FETCH at N+2, giving 2 cycles.
- `IllegalInstr` is high in the DECODE cycle only.
- `RegNum` is valid in the same cycle as `RegCE`/`AccuCE`. The register file read path is combinational, so the accumulator captures the operand at the end of the READ cycle.
- Back-to-back ST then LD to the same register: the write completes at the end of WRITE, and the LD's READ, at least 2 cycles later, sees the new value. No forwarding is needed.
- `Halted` rises in the cycle after DECODE of HALT.

## Structure
- Package `uproc_pkg`:
  - `opcode_e` (4-bit), `alu_op_e` (3-bit), `id_state_e` (FETCH, DECODE, READ, WRITE, HALT).
  - Constants `NUM_REGS`=4, `RO_MASK_DEFAULT`=4'b1000.
- Sub-module `reg_sel_dec`: 2-bit index → NUM_REGS one-hot, with an enable input; output is all-zero when disabled.
- State register, instruction register and output decode live in `instr_decode`.

## Test plan
- Reset: drive `Reset` 1 for 2 cycles. Require all outputs 0, `InstrReady`=1 the cycle after release.
- LD R1 (0x11): handshake at N. Require `RegNum`=4'b0010, `AccuCE`=1, `AluOp`=0 at N+2 only, and `InstrReady`=1 again at N+3.
- ST R2 (0x22) then ADD R2 (0x32) back-to-back:
  - At ST's WRITE cycle, `RegNum`=4'b0100 and `RegCE`=1 for exactly 1 cycle.
  - ADD's READ asserts `AccuCE`=1 with `AluOp`=1.
  - `RegCE` and `AccuCE` are never both 1.
- Illegal: ST R3 (0x23) and opcode 0x9 (0x90). Each requires an `IllegalInstr` 1-cycle pulse at N+1, no `RegCE`/`AccuCE`, and ready at N+2.
- HALT (0xF0): `Halted`=1 from N+2. Then `InstrValid`=1 with 0x11 for 10 cycles gets no acceptance and no enables. `Reset` clears `Halted`.
- Reset mid-WRITE: assert `Reset` in ST R0's WRITE cycle. Require `RegCE`=0 that cycle and state FETCH next cycle.
